// File: rtl/canvas_pkg.sv
// canvas_pkg: constants shared by the colour selector, canvas_writer and VGA scan-out.
// Holds the canvas geometry defaults, the 3-bit colour codes and the writer state enum.
package canvas_pkg;

  // Default canvas geometry and brush size
  localparam int DEFAULT_CANVAS_W = 160;
  localparam int DEFAULT_CANVAS_H = 120;
  localparam int DEFAULT_BRUSH    = 3;

  // Writer FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    STROKE = 2'b01,
    CLEAR  = 2'b10
  } canvas_state_e;

  // 3-bit colour codes; white doubles as the erase colour
  localparam logic [2:0] COLOR_BLACK   = 3'b000;
  localparam logic [2:0] COLOR_BLUE    = 3'b001;
  localparam logic [2:0] COLOR_GREEN   = 3'b010;
  localparam logic [2:0] COLOR_CYAN    = 3'b011;
  localparam logic [2:0] COLOR_RED     = 3'b100;
  localparam logic [2:0] COLOR_MAGENTA = 3'b101;
  localparam logic [2:0] COLOR_YELLOW  = 3'b110;
  localparam logic [2:0] COLOR_WHITE   = 3'b111;

endpackage

// File: rtl/canvas_writer_brush_scan.sv
// brush_scan: walks the brush offsets dx/dy = -R..R row-major around a latched
// cursor, reporting whether the current pixel lies on the canvas, its linear
// address and whether this is the final offset. The row base address is
// accumulated (+CANVAS_W per row) so no multiplier is needed.
module brush_scan
  import canvas_pkg::*;
#(
  parameter int CANVAS_W = DEFAULT_CANVAS_W,
  parameter int CANVAS_H = DEFAULT_CANVAS_H,
  parameter int BRUSH    = DEFAULT_BRUSH,
  parameter int X_W      = $clog2(CANVAS_W),
  parameter int Y_W      = $clog2(CANVAS_H),
  parameter int ADDR_W   = $clog2(CANVAS_W * CANVAS_H)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              advance,
  input  logic [X_W-1:0]    cursor_x,
  input  logic [Y_W-1:0]    cursor_y,
  output logic              in_bounds,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam int OW = 5;
  localparam int R  = (BRUSH - 1) / 2;
  localparam logic signed [OW-1:0] R_S     = OW'(R);
  localparam logic signed [OW-1:0] NEG_R_S = -R_S;
  localparam logic [31:0]          CW_K    = 32'(CANVAS_W);
  localparam logic [ADDR_W-1:0]    ROW_STEP    = ADDR_W'(CANVAS_W);
  localparam logic [ADDR_W-1:0]    ROW_OFFSET  = ADDR_W'(R * CANVAS_W);
  localparam logic [X_W:0]         CW_LIMIT    = (X_W + 1)'(CANVAS_W);
  localparam logic [Y_W:0]         CH_LIMIT    = (Y_W + 1)'(CANVAS_H);

  // Shift-and-add y*CANVAS_W; CANVAS_W is constant so this folds to a few adders.
  // Arithmetic is modulo 2^ADDR_W, which is exact for every in-bounds pixel.
  function automatic logic [ADDR_W-1:0] row_base_of(input logic [Y_W-1:0] y);
    logic [ADDR_W-1:0] acc;
    logic [ADDR_W-1:0] yw;
    acc = '0;
    yw  = ADDR_W'(y);
    for (int i = 0; i < 32; i++) begin
      if (CW_K[i]) begin
        acc = acc + (yw << i);
      end else begin
        acc = acc;
      end
    end
    return acc;
  endfunction

  logic signed [OW-1:0] dx_r;
  logic signed [OW-1:0] dy_r;
  logic [X_W-1:0]       cx_r;
  logic [Y_W-1:0]       cy_r;
  logic [ADDR_W-1:0]    row_base_r;
  logic signed [X_W:0]  x_s;
  logic signed [Y_W:0]  y_s;

  // Offset counters and row base: load at stroke start, step once per cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dx_r       <= '0;
      dy_r       <= '0;
      cx_r       <= '0;
      cy_r       <= '0;
      row_base_r <= '0;
    end else if (start) begin
      dx_r       <= NEG_R_S;
      dy_r       <= NEG_R_S;
      cx_r       <= cursor_x;
      cy_r       <= cursor_y;
      row_base_r <= row_base_of(cursor_y) - ROW_OFFSET;
    end else if (advance) begin
      if (dx_r == R_S) begin
        dx_r       <= NEG_R_S;
        dy_r       <= dy_r + OW'(1);
        row_base_r <= row_base_r + ROW_STEP;
      end else begin
        dx_r       <= dx_r + OW'(1);
      end
    end else begin
      dx_r       <= dx_r;
      dy_r       <= dy_r;
      row_base_r <= row_base_r;
    end
  end

  // Pixel coordinates, bounds check and linear address of the current offset
  always_comb begin
    x_s       = $signed({1'b0, cx_r}) + (X_W + 1)'(dx_r);
    y_s       = $signed({1'b0, cy_r}) + (Y_W + 1)'(dy_r);
    in_bounds = !x_s[X_W] && ($unsigned(x_s) < CW_LIMIT) &&
                !y_s[Y_W] && ($unsigned(y_s) < CH_LIMIT);
    addr      = row_base_r + ADDR_W'(x_s);
    last      = (dx_r == R_S) && (dy_r == R_S);
  end

endmodule

// File: rtl/canvas_writer.sv
// canvas_writer: converts paint/clear requests into one-pixel-per-clock writes
// on the canvas frame-buffer port. Paint stamps a BRUSH x BRUSH square around the
// cursor; clear floods the canvas white. All outputs are registered.
// Optional build macro CANVAS_REPEAT_FILTER_EN: suppress a paint request whose
// cursor and colour match the last completed stroke (cleared by CLEAR or rst).
module canvas_writer
  import canvas_pkg::*;
#(
  parameter int CANVAS_W = DEFAULT_CANVAS_W,
  parameter int CANVAS_H = DEFAULT_CANVAS_H,
  parameter int BRUSH    = DEFAULT_BRUSH,
  localparam int X_W     = $clog2(CANVAS_W),
  localparam int Y_W     = $clog2(CANVAS_H),
  localparam int ADDR_W  = $clog2(CANVAS_W * CANVAS_H)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        color,
  input  logic [X_W-1:0]    cursor_x,
  input  logic [Y_W-1:0]    cursor_y,
  input  logic              paint,
  input  logic              clear,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [2:0]        wdata,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CANVAS_W * CANVAS_H - 1);

  canvas_state_e     state_r;
  canvas_state_e     state_next;
  logic              scan_start_s;
  logic              scan_adv_s;
  logic              clr_start_s;
  logic              repeat_hit_s;
  logic              scan_in_bounds_s;
  logic              scan_last_s;
  logic [ADDR_W-1:0] scan_addr_s;
  logic [2:0]        color_r;
  logic [ADDR_W-1:0] clr_addr_r;
  logic              we_r;
  logic [ADDR_W-1:0] waddr_r;
  logic [2:0]        wdata_r;
  logic              busy_r;

  brush_scan #(
    .CANVAS_W (CANVAS_W),
    .CANVAS_H (CANVAS_H),
    .BRUSH    (BRUSH),
    .X_W      (X_W),
    .Y_W      (Y_W),
    .ADDR_W   (ADDR_W)
  ) u_brush_scan (
    .clk       (clk),
    .rst       (rst),
    .start     (scan_start_s),
    .advance   (scan_adv_s),
    .cursor_x  (cursor_x),
    .cursor_y  (cursor_y),
    .in_bounds (scan_in_bounds_s),
    .addr      (scan_addr_s),
    .last      (scan_last_s)
  );

`ifdef CANVAS_REPEAT_FILTER_EN
  logic           rec_valid_r;
  logic [X_W-1:0] rec_x_r;
  logic [Y_W-1:0] rec_y_r;
  logic [2:0]     rec_color_r;
  logic [X_W-1:0] stroke_x_r;
  logic [Y_W-1:0] stroke_y_r;

  // Remember the stroke in flight and record it once its last pixel is issued
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rec_valid_r <= 1'b0;
      rec_x_r     <= '0;
      rec_y_r     <= '0;
      rec_color_r <= 3'b000;
      stroke_x_r  <= '0;
      stroke_y_r  <= '0;
    end else begin
      if (scan_start_s) begin
        stroke_x_r <= cursor_x;
        stroke_y_r <= cursor_y;
      end else begin
        stroke_x_r <= stroke_x_r;
        stroke_y_r <= stroke_y_r;
      end
      if ((state_r == STROKE) && scan_last_s) begin
        rec_valid_r <= 1'b1;
        rec_x_r     <= stroke_x_r;
        rec_y_r     <= stroke_y_r;
        rec_color_r <= color_r;
      end else if ((state_r == CLEAR) && (clr_addr_r == LAST_ADDR)) begin
        rec_valid_r <= 1'b0;
      end else begin
        rec_valid_r <= rec_valid_r;
      end
    end
  end

  assign repeat_hit_s = rec_valid_r && (cursor_x == rec_x_r) &&
                        (cursor_y == rec_y_r) && (color == rec_color_r);
`else
  assign repeat_hit_s = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next;
    end
  end

  // FSM next state and control strobes; clear wins over paint in IDLE
  always_comb begin
    state_next   = state_r;
    scan_start_s = 1'b0;
    scan_adv_s   = 1'b0;
    clr_start_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (clear) begin
          state_next  = CLEAR;
          clr_start_s = 1'b1;
        end else if (paint && !repeat_hit_s) begin
          state_next   = STROKE;
          scan_start_s = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      STROKE: begin
        scan_adv_s = 1'b1;
        if (scan_last_s) begin
          state_next = IDLE;
        end else begin
          state_next = STROKE;
        end
      end
      CLEAR: begin
        if (clr_addr_r == LAST_ADDR) begin
          state_next = IDLE;
        end else begin
          state_next = CLEAR;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Stroke colour latch and clear sweep address
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      color_r    <= 3'b000;
      clr_addr_r <= '0;
    end else begin
      if (scan_start_s) begin
        color_r <= color;
      end else begin
        color_r <= color_r;
      end
      if (clr_start_s) begin
        clr_addr_r <= '0;
      end else if (state_r == CLEAR) begin
        clr_addr_r <= clr_addr_r + ADDR_W'(1);
      end else begin
        clr_addr_r <= clr_addr_r;
      end
    end
  end

  // Register the write port from the current brush offset or sweep address
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_r    <= 1'b0;
      waddr_r <= '0;
      wdata_r <= 3'b000;
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        STROKE: begin
          we_r    <= scan_in_bounds_s;
          if (scan_in_bounds_s) begin
            waddr_r <= scan_addr_s;
          end else begin
            waddr_r <= waddr_r;
          end
          wdata_r <= color_r;
          busy_r  <= 1'b1;
        end
        CLEAR: begin
          we_r    <= 1'b1;
          waddr_r <= clr_addr_r;
          wdata_r <= COLOR_WHITE;
          busy_r  <= 1'b1;
        end
        default: begin
          we_r    <= 1'b0;
          waddr_r <= waddr_r;
          wdata_r <= wdata_r;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign we    = we_r;
  assign waddr = waddr_r;
  assign wdata = wdata_r;
  assign busy  = busy_r;

endmodule

// File: tb/tb_canvas_writer.sv
// tb_canvas_writer: table-driven brush strokes plus hand-written clear, reset
// and held-paint sequences. Expected pixel writes come from a small geometric
// model and are queued when stimulus is applied, then popped per DUT write.
module tb_canvas_writer;

  localparam int W      = 160;
  localparam int H      = 120;
  localparam int BRUSH  = 3;
  localparam int R      = (BRUSH - 1) / 2;
  localparam int X_W    = 8;
  localparam int Y_W    = 7;
  localparam int ADDR_W = 15;
`ifdef CANVAS_REPEAT_FILTER_EN
  localparam int STROKES_PER_HOLD = 1;
`else
  localparam int STROKES_PER_HOLD = 3;
`endif

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [2:0]        data;
  } exp_t;

  typedef struct {
    int         cx;
    int         cy;
    logic [2:0] col;
    int         exp_writes;
  } stroke_vec_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [2:0]        color = 3'b000;
  logic [X_W-1:0]    cursor_x = '0;
  logic [Y_W-1:0]    cursor_y = '0;
  logic              paint = 1'b0;
  logic              clear = 1'b0;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [2:0]        wdata;
  logic              busy;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   write_cnt = 0;

  canvas_writer dut (
    .clk      (clk),
    .rst      (rst),
    .color    (color),
    .cursor_x (cursor_x),
    .cursor_y (cursor_y),
    .paint    (paint),
    .clear    (clear),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: every DUT write must match the head of the expected queue
  always @(negedge clk) begin
    if (!rst && we) begin
      write_cnt++;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: got addr=%0d data=%0b, expected no write", waddr, wdata);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (waddr !== e.addr || wdata !== e.data) begin
          fails++;
          $display("FAIL write: got addr=%0d data=%0b, expected addr=%0d data=%0b",
                   waddr, wdata, e.addr, e.data);
        end
      end
    end
  end

  task automatic push_stroke(input int cx, input int cy, input logic [2:0] col);
    int x;
    int y;
    for (int dy = -R; dy <= R; dy++) begin
      for (int dx = -R; dx <= R; dx++) begin
        x = cx + dx;
        y = cy + dy;
        if (x >= 0 && x < W && y >= 0 && y < H) begin
          exp_q.push_back('{addr: ADDR_W'(y * W + x), data: col});
        end
      end
    end
  endtask

  task automatic run_stroke(input int cx, input int cy, input logic [2:0] col,
                            input int exp_writes, input string name);
    int busy_cycles;
    int w0;
    @(negedge clk);
    w0       = write_cnt;
    cursor_x = X_W'(cx);
    cursor_y = Y_W'(cy);
    color    = col;
    paint    = 1'b1;
    push_stroke(cx, cy, col);
    @(negedge clk);
    paint = 1'b0;
    check({name, "_busy_after_accept"}, int'(busy), 0);
    @(negedge clk);
    check({name, "_busy_first"}, int'(busy), 1);
    busy_cycles = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) busy_cycles++;
      else break;
    end
    check({name, "_busy_cycles"}, busy_cycles, BRUSH * BRUSH);
    check({name, "_writes"}, write_cnt - w0, exp_writes);
    check({name, "_queue_left"}, exp_q.size(), 0);
  endtask

  task automatic hold_paint(input logic [2:0] col, input string name);
    int rises;
    int first_rise;
    int second_rise;
    int w0;
    logic prev;
    @(negedge clk);
    w0       = write_cnt;
    cursor_x = X_W'(50);
    cursor_y = Y_W'(50);
    color    = col;
    paint    = 1'b1;
    for (int k = 0; k < STROKES_PER_HOLD; k++) push_stroke(50, 50, col);
    prev = 1'b0;
    rises = 0;
    first_rise = 0;
    second_rise = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (cyc == 21) paint = 1'b0;
      if (busy && !prev) begin
        rises++;
        if (rises == 1) first_rise = cyc;
        else if (rises == 2) second_rise = cyc;
      end
      prev = busy;
    end
    paint = 1'b0;
    check({name, "_strokes"}, rises, STROKES_PER_HOLD);
    check({name, "_writes"}, write_cnt - w0, 9 * STROKES_PER_HOLD);
    check({name, "_queue_left"}, exp_q.size(), 0);
`ifndef CANVAS_REPEAT_FILTER_EN
    check({name, "_period"}, second_rise - first_rise, 10);
`endif
  endtask

  stroke_vec_t vecs[8];

  initial begin
    int busy_cycles;
    int w0;
    bit done;

    vecs[0] = '{cx: 10,  cy: 20,  col: 3'b001, exp_writes: 9};
    vecs[1] = '{cx: 0,   cy: 0,   col: 3'b010, exp_writes: 4};
    vecs[2] = '{cx: 159, cy: 119, col: 3'b011, exp_writes: 4};
    vecs[3] = '{cx: 0,   cy: 60,  col: 3'b100, exp_writes: 6};
    vecs[4] = '{cx: 80,  cy: 0,   col: 3'b101, exp_writes: 6};
    vecs[5] = '{cx: 159, cy: 0,   col: 3'b110, exp_writes: 4};
    vecs[6] = '{cx: 0,   cy: 119, col: 3'b111, exp_writes: 4};
    vecs[7] = '{cx: 80,  cy: 60,  col: 3'b000, exp_writes: 9};

    // Reset state
    #12;
    check("rst_we", int'(we), 0);
    check("rst_waddr", int'(waddr), 0);
    check("rst_wdata", int'(wdata), 0);
    check("rst_busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Table-driven strokes
    for (int i = 0; i < 8; i++) begin
      run_stroke(vecs[i].cx, vecs[i].cy, vecs[i].col, vecs[i].exp_writes,
                 $sformatf("vec%0d", i));
      repeat (2) @(negedge clk);
    end

    // Clear and paint together: full white sweep first, then the stroke
    @(negedge clk);
    w0       = write_cnt;
    cursor_x = X_W'(70);
    cursor_y = Y_W'(30);
    color    = 3'b010;
    clear    = 1'b1;
    paint    = 1'b1;
    for (int a = 0; a < W * H; a++) exp_q.push_back('{addr: ADDR_W'(a), data: 3'b111});
    push_stroke(70, 30, 3'b010);
    @(negedge clk);
    clear = 1'b0;
    busy_cycles = 0;
    done = 1'b0;
    for (int i = 0; i < 19300 && !done; i++) begin
      @(negedge clk);
      if (busy) busy_cycles++;
      else if (busy_cycles > 0) done = 1'b1;
    end
    paint = 1'b0;
    check("clear_busy_cycles", busy_cycles, W * H);
    busy_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) busy_cycles++;
      else if (busy_cycles > 0) break;
    end
    check("post_clear_stroke_busy", busy_cycles, 9);
    check("clear_total_writes", write_cnt - w0, W * H + 9);
    check("clear_queue_left", exp_q.size(), 0);
    repeat (3) @(negedge clk);

    // Held paint: repeat behaviour and colour change
    hold_paint(3'b100, "hold_c4");
    repeat (3) @(negedge clk);
    hold_paint(3'b101, "hold_c5");
    repeat (3) @(negedge clk);

    // Reset in the middle of a clear
    @(negedge clk);
    clear = 1'b1;
    for (int a = 0; a < W * H; a++) exp_q.push_back('{addr: ADDR_W'(a), data: 3'b111});
    @(negedge clk);
    clear = 1'b0;
    repeat (100) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midclr_rst_we", int'(we), 0);
    check("midclr_rst_busy", int'(busy), 0);
    check("midclr_rst_waddr", int'(waddr), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("after_rst_busy", int'(busy), 0);
    check("after_rst_we", int'(we), 0);
    run_stroke(10, 20, 3'b001, 9, "after_rst_stroke");
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
